// File: rtl/dm_responder_pkg.sv
// Shared definitions for the SCPU data-memory responder: access-size codes,
// MMIO register offsets and the alignment rule used by both stores and loads.
package dm_responder_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_F000;

  localparam logic [31:0] OFF_LED       = 32'h0000_0000;
  localparam logic [31:0] OFF_CYCLE     = 32'h0000_0004;
  localparam logic [31:0] OFF_STORE_CNT = 32'h0000_0008;
  localparam logic [31:0] OFF_ERR       = 32'h0000_000C;
  localparam logic [31:0] OFF_ERR_ADDR  = 32'h0000_0010;

  // MMIO registers are word-only, so any sub-word access there is an error.
  function automatic logic dm_misaligned(input logic [2:0] dm_type,
                                         input logic [1:0] lsb,
                                         input logic       is_mmio);
    logic bad;
    bad = 1'b0;
    case (dm_type)
      DM_WORD:            bad = (lsb != 2'b00);
      DM_HALF, DM_HALF_U: bad = lsb[0] | is_mmio;
      DM_BYTE, DM_BYTE_U: bad = is_mmio;
      default:            bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load path: picks the addressed byte/half lane out of a RAM word and
// sign- or zero-extends it to 32 bits.
module dm_lane_ext
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [15:0] half_v;
  logic [7:0]  lane_b;

  always_comb begin
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase

    data = word;
    case (dm_type)
      DM_HALF:   data = {{16{half_v[15]}}, half_v};
      DM_HALF_U: data = {16'h0000, half_v};
      DM_BYTE:   data = {{24{lane_b[7]}}, lane_b};
      DM_BYTE_U: data = {24'h00_0000, lane_b};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// MEM-stage data port for the pipelined SCPU: RAM with lane-masked stores,
// combinational loads, and a small MMIO window of counters and status.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
  parameter int          LED_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       dm_type,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic             err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]      ram_q [DEPTH_WORDS];
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cycle_q, cycle_d;
  logic [31:0]      store_cnt_q, store_cnt_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic             is_mmio, misaligned, store_ok, ram_we;
  logic [31:0]      mmio_off, mmio_rd, ram_word, lane_data, wlane;
  logic [3:0]       be;
  logic [AW-1:0]    idx;

  assign idx      = addr[AW+1:2];
  assign ram_word = ram_q[idx];

  dm_lane_ext u_lane_ext (
    .word    (ram_word),
    .offset  (addr[1:0]),
    .dm_type (dm_type),
    .data    (lane_data)
  );

  always_comb begin
    is_mmio    = (addr >= MMIO_BASE);
    mmio_off   = addr - MMIO_BASE;
    misaligned = dm_misaligned(dm_type, addr[1:0], is_mmio);
    store_ok   = mem_w & ~misaligned;
    ram_we     = store_ok & ~is_mmio;

    be    = 4'hF;
    wlane = wdata;
    case (dm_type)
      DM_HALF, DM_HALF_U: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      DM_BYTE, DM_BYTE_U: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      default: begin
        be    = 4'hF;
        wlane = wdata;
      end
    endcase
  end

  // Counters and status are read as their pre-edge values.
  always_comb begin
    mmio_rd = 32'h0;
    case (mmio_off)
      OFF_LED:       mmio_rd = 32'(led_q);
      OFF_CYCLE:     mmio_rd = cycle_q;
      OFF_STORE_CNT: mmio_rd = store_cnt_q;
      OFF_ERR:       mmio_rd = {31'h0, err_q};
      OFF_ERR_ADDR:  mmio_rd = err_addr_q;
      default:       mmio_rd = 32'h0;
    endcase

    if (!rstn || misaligned)
      rdata = 32'h0;
    else if (is_mmio)
      rdata = mmio_rd;
    else
      rdata = lane_data;
  end

  // A fresh error wins over a same-cycle W1C, and only the first address is kept.
  always_comb begin
    led_d       = led_q;
    cycle_d     = cycle_q + 32'd1;
    store_cnt_d = store_cnt_q + 32'(ram_we);
    err_d       = err_q;
    err_addr_d  = err_addr_q;

    if (store_ok && is_mmio) begin
      if (mmio_off == OFF_LED)
        led_d = wdata[LED_W-1:0];
      if (mmio_off == OFF_ERR && wdata[0])
        err_d = 1'b0;
    end

    if (misaligned) begin
      err_d = 1'b1;
      if (!err_q)
        err_addr_d = addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_q       <= '0;
      cycle_q     <= 32'h0;
      store_cnt_q <= 32'h0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      led_q       <= led_d;
      cycle_q     <= cycle_d;
      store_cnt_q <= store_cnt_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // RAM is never reset; a store landing on an edge during reset is dropped.
  always_ff @(posedge clk) begin
    if (rstn && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          ram_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign led = led_q;
  assign err = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus randomized
// traffic compared against a byte-array memory and register model.
module tb_dm_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_F000;
  localparam int          LEDW  = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             mem_w = 1'b0;
  logic [31:0]      addr = 32'h0;
  logic [31:0]      wdata = 32'h0;
  logic [2:0]       dm_type = 3'd0;
  logic [31:0]      rdata;
  logic [LEDW-1:0]  led;
  logic             err;

  int nChecks = 0;
  int nFails  = 0;

  // Reference state: RAM as little-endian bytes, MMIO as plain variables.
  logic [7:0]      refMem [DEPTH*4];
  logic [LEDW-1:0] refLed;
  logic [31:0]     refCycle, refStoreCnt, refErrAddr;
  logic            refErr;
  logic [31:0]     lastRdata;

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH_WORDS (DEPTH),
    .MMIO_BASE   (BASE),
    .LED_W       (LEDW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .mem_w   (mem_w),
    .addr    (addr),
    .wdata   (wdata),
    .dm_type (dm_type),
    .rdata   (rdata),
    .led     (led),
    .err     (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic refBad(input logic [31:0] a, input logic [2:0] t);
    if (t > 3'd4) return 1'b1;
    if (a >= BASE) return (t != 3'd0) || (a % 4 != 0);
    if (t == 3'd0) return (a % 4 != 0);
    if (t == 3'd1 || t == 3'd2) return (a % 2 != 0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] off;
    logic [15:0] h;
    logic [7:0]  v;
    int          b;
    if (refBad(a, t)) return 32'h0;
    if (a >= BASE) begin
      off = a - BASE;
      case (off)
        32'h00:  return 32'(refLed);
        32'h04:  return refCycle;
        32'h08:  return refStoreCnt;
        32'h0C:  return {31'h0, refErr};
        32'h10:  return refErrAddr;
        default: return 32'h0;
      endcase
    end
    b = int'(a % (DEPTH * 4));
    case (t)
      3'd0: return {refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]};
      3'd1: begin h = {refMem[b+1], refMem[b]}; return {{16{h[15]}}, h}; end
      3'd2: begin h = {refMem[b+1], refMem[b]}; return {16'h0, h}; end
      3'd3: begin v = refMem[b]; return {{24{v[7]}}, v}; end
      default: begin v = refMem[b]; return {24'h0, v}; end
    endcase
  endfunction

  task automatic refCommit(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    int b;
    refCycle++;
    if (refBad(a, t)) begin
      if (!refErr) refErrAddr = a;
      refErr = 1'b1;
    end else if (w) begin
      if (a >= BASE) begin
        if (a - BASE == 32'h0) refLed = d[LEDW-1:0];
        else if (a - BASE == 32'hC && d[0]) refErr = 1'b0;
      end else begin
        b = int'(a % (DEPTH * 4));
        case (t)
          3'd0: for (int k = 0; k < 4; k++) refMem[b+k] = d[8*k +: 8];
          3'd1, 3'd2: begin refMem[b] = d[7:0]; refMem[b+1] = d[15:8]; end
          default: refMem[b] = d[7:0];
        endcase
        refStoreCnt++;
      end
    end
  endtask

  task automatic resetModel();
    refLed = '0; refCycle = 32'h0; refStoreCnt = 32'h0;
    refErr = 1'b0; refErrAddr = 32'h0;
  endtask

  // One access per clock: drive, sample the combinational load, take the edge.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] t, input bit chk, input string tag);
    mem_w = w; addr = a; wdata = d; dm_type = t;
    #1;
    lastRdata = rdata;
    if (chk) checkOutput(tag, rdata, refLoad(a, t));
    @(posedge clk);
    #1;
    refCommit(w, a, d, t);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, "idle");
  endtask

  initial begin
    logic [31:0] c1;
    logic [31:0] a, d;
    logic [2:0]  t;
    logic        w;
    int          kind;
    logic [31:0] mmioOffs [6];

    mmioOffs[0] = 32'h00; mmioOffs[1] = 32'h04; mmioOffs[2] = 32'h08;
    mmioOffs[3] = 32'h0C; mmioOffs[4] = 32'h10; mmioOffs[5] = 32'h14;

    resetModel();
    rstn = 1'b0;
    #2;
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 3'd0, 1'b1, "cycle_after_reset");
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3'd0, 1'b1, "storecnt_after_reset");

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 1'b0, "sw");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, "lw_deadbeef");
    checkOutput("lw_deadbeef_const", lastRdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3'd0, 1'b1, "storecnt_one");
    checkOutput("storecnt_one_const", lastRdata, 32'h1);

    applyStimulus(1'b1, 32'h10, 32'h1122_3344, 3'd0, 1'b0, "sw");
    applyStimulus(1'b1, 32'h13, 32'h0000_0080, 3'd3, 1'b0, "sb");
    applyStimulus(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, "lw_after_sb");
    checkOutput("lw_after_sb_const", lastRdata, 32'h8022_3344);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'd3, 1'b1, "lb");
    checkOutput("lb_const", lastRdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 32'h13, 32'h0, 3'd4, 1'b1, "lbu");
    applyStimulus(1'b0, 32'h12, 32'h0, 3'd1, 1'b1, "lh");
    checkOutput("lh_const", lastRdata, 32'hFFFF_8022);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'd2, 1'b1, "lhu");

    applyStimulus(1'b1, 32'h20, 32'h0BAD_F00D, 3'd0, 1'b0, "sw");
    applyStimulus(1'b1, 32'h21, 32'h0000_0005, 3'd0, 1'b0, "sw_misaligned");
    checkOutput("err_set", {31'h0, err}, 32'h1);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'd0, 1'b1, "word_unchanged");
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 3'd0, 1'b1, "err_addr");
    checkOutput("err_addr_const", lastRdata, 32'h21);
    applyStimulus(1'b0, 32'h22, 32'h0, 3'd0, 1'b1, "lw_misaligned");
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 3'd0, 1'b1, "err_addr_kept");
    applyStimulus(1'b1, BASE + 32'hC, 32'h1, 3'd0, 1'b0, "w1c");
    checkOutput("err_cleared", {31'h0, err}, 32'h0);

    applyStimulus(1'b1, BASE, 32'h0000_ABCD, 3'd0, 1'b0, "led_write");
    checkOutput("led_value", 32'(led), 32'h0000_ABCD);
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3'd0, 1'b1, "storecnt_no_mmio");

    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 3'd0, 1'b1, "cycle_a");
    c1 = lastRdata;
    idle();
    idle();
    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 3'd0, 1'b1, "cycle_b");
    checkOutput("cycle_delta", lastRdata - c1, 32'd3);

    applyStimulus(1'b1, 32'(DEPTH * 4), 32'h5A5A_1234, 3'd0, 1'b0, "sw_wrap");
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, "wrap_alias");

    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 32'(4 * i), $urandom, 3'd0, 1'b0, "init");

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (kind < 2) begin
        a = BASE + mmioOffs[$urandom_range(0, 5)];
        t = 3'd0;
        if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 5) == 0) t = 3'($urandom_range(1, 7));
      end else begin
        t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (t == 3'd0) a = a & ~32'h3;
          else if (t == 3'd1 || t == 3'd2) a = a & ~32'h1;
        end
        if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4 * $urandom_range(1, 3));
      end
      applyStimulus(w, a, d, t, !w, "rnd_load");
      checkOutput("rnd_err", {31'h0, err}, {31'h0, refErr});
      checkOutput("rnd_led", 32'(led), 32'(refLed));
    end
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3'd0, 1'b1, "rnd_storecnt");
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 3'd0, 1'b1, "rnd_err_addr");

    applyStimulus(1'b1, 32'h40, 32'h1234_5678, 3'd0, 1'b0, "sw_target");
    applyStimulus(1'b1, BASE, 32'h0000_00FF, 3'd0, 1'b0, "led_write");
    applyStimulus(1'b0, 32'h41, 32'h0, 3'd0, 1'b0, "make_err");
    mem_w = 1'b1; addr = 32'h40; wdata = 32'hCAFE_F00D; dm_type = 3'd0;
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_rdata", rdata, 32'h0);
    checkOutput("midrst_led", 32'(led), 32'h0);
    checkOutput("midrst_err", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    mem_w = 1'b0;
    rstn = 1'b1;
    resetModel();
    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 3'd0, 1'b1, "midrst_cycle");
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3'd0, 1'b1, "midrst_storecnt");
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 3'd0, 1'b1, "midrst_err_addr");
    applyStimulus(1'b0, 32'h40, 32'h0, 3'd0, 1'b1, "midrst_target");
    checkOutput("midrst_target_const", lastRdata, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
